sequence_player: RTL

//  Plays back the first round_len entries of the sequence ROM filled by the

---
 rtl/sequence_player.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sequence_player.sv
// Plays back the first round_len colours of the sequence ROM as one-hot LED flashes,
// each lit for ON_TICKS ticks and then dark for GAP_TICKS ticks, and pulses done at the end.
module sequence_player #(
  parameter int N         = 10,
  parameter int ADDR_W    = 4,
  parameter int ON_TICKS  = 8,
  parameter int GAP_TICKS = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] round_len,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ON,
    S_GAP,
    S_FIN
  } state_e;

  localparam logic [ADDR_W-1:0] MAX_LEN  = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_TICKS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        led_q;
  logic              busy_q;
  logic              done_q;

  logic [ADDR_W-1:0] len_d;
  logic [ADDR_W-1:0] idx_d;

  // Requests longer than the ROM are clamped so exactly N entries play.
  assign len_d = (round_len > MAX_LEN) ? MAX_LEN : round_len;
  assign idx_d = idx_q + ADDR_ONE;

  function automatic logic [3:0] onehot(input logic [1:0] colour);
    logic [3:0] res;
    res = 4'b0000;
    res[colour] = 1'b1;
    return res;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      led_q     <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort) begin
      // Abort beats everything, including a start seen in the same cycle.
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      led_q     <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          led_q <= 4'b0000;
          if (start) begin
            len_q <= len_d;
            idx_q <= '0;
            cnt_q <= '0;
            if (len_d == ADDR_ZERO) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              rd_addr_q <= '0;
              busy_q    <= 1'b1;
              state_q   <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          state_q <= S_LATCH;
        end

        S_LATCH: begin
          led_q   <= onehot(rd_data);
          cnt_q   <= '0;
          state_q <= S_ON;
        end

        S_ON: begin
          if (tick) begin
            if (cnt_q == ON_LAST) begin
              led_q   <= 4'b0000;
              cnt_q   <= '0;
              state_q <= S_GAP;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        // idx is parked at 0 after the last entry so it never points past the ROM.
        S_GAP: begin
          led_q <= 4'b0000;
          if (tick) begin
            if (cnt_q == GAP_LAST) begin
              cnt_q <= '0;
              if (idx_d == len_q) begin
                idx_q   <= '0;
                state_q <= S_FIN;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                idx_q     <= idx_d;
                rd_addr_q <= idx_d;
                state_q   <= S_FETCH;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          led_q   <= 4'b0000;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_addr = rd_addr_q;
  assign led     = led_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
